// File: rtl/xadc_multi_monitor.sv
// DRP-master sequencer for the 7-series XADC: reads the sensor channel named by each
// end-of-conversion, optionally box-car averages, publishes results and hysteresis alarms.
module xadc_multi_monitor #(
    parameter int                   NUM_CH    = 4,
    parameter logic [7*NUM_CH-1:0]  CH_ADDR   = {7'h06, 7'h02, 7'h01, 7'h00},
    parameter int                   AVG_LOG2  = 0,
    parameter logic [12*NUM_CH-1:0] HI_THRESH = {4{12'hFFF}},
    parameter logic [11:0]          HYST      = 12'd16,
    parameter int                   TIMEOUT   = 64
) (
    input  logic                   clk210_p,
    input  logic                   reset_n_p,
    input  logic                   eoc_p,
    input  logic [4:0]             channel_p,
    output logic [6:0]             drp_daddr_p,
    output logic                   drp_den_p,
    output logic                   drp_dwe_p,
    output logic [15:0]            drp_di_p,
    input  logic [15:0]            drp_do_p,
    input  logic                   drp_drdy_p,
    output logic [16*NUM_CH-1:0]   data_p,
    output logic [NUM_CH-1:0]      valid_p,
    output logic [NUM_CH-1:0]      alarm_p,
    output logic                   timeout_p,
    output logic                   overrun_p
);

    // state  | meaning
    // IDLE   | waiting for an eoc on a mapped channel
    // REQ    | one-cycle DRP read strobe
    // WAIT   | waiting for drdy, timeout timer running
    // UPDATE | fold sample into accumulator, publish on wrap
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_UPDATE} state_t;

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, hit_idx;
    logic [6:0]      hit_addr;
    logic            hit;
    logic [TW-1:0]   tmr;
    logic            tc;
    logic [11:0]     code_q;
    logic [AW-1:0]   acc [NUM_CH];
    logic [CW-1:0]   cnt [NUM_CH];
    logic [AW-1:0]   acc_sel, sum;
    logic [CW-1:0]   cnt_sel;
    logic [11:0]     thr_sel, thr_lo, result;
    logic            wrap;
    logic            start, capture, expire, upd;
    logic            unused_do;

    assign unused_do  = &{1'b0, drp_do_p[3:0]};
    assign drp_dwe_p  = 1'b0;
    assign drp_di_p   = 16'd0;
    assign tc         = (tmr == TW'(1));

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_addr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ({2'b00, channel_p} == CH_ADDR[7*i +: 7]) begin
                hit      = 1'b1;
                hit_idx  = IW'(i);
                hit_addr = CH_ADDR[7*i +: 7];
            end
        end
    end

    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        thr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IW'(i)) begin
                acc_sel = acc[i];
                cnt_sel = cnt[i];
                thr_sel = HI_THRESH[12*i +: 12];
            end
        end
    end

    assign sum    = acc_sel + AW'(code_q);
    assign result = sum[AW-1:AVG_LOG2];
    assign wrap   = (int'(cnt_sel) == (1 << AVG_LOG2) - 1);
    assign thr_lo = (thr_sel >= HYST) ? (thr_sel - HYST) : 12'd0;

    always_ff @(posedge clk210_p) begin
        if (!reset_n_p) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (eoc_p && hit) state_nxt = S_REQ;
            S_REQ:    state_nxt = S_WAIT;
            S_WAIT:   if (drp_drdy_p) state_nxt = S_UPDATE;
                      else if (tc)    state_nxt = S_IDLE;
            S_UPDATE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        drp_den_p = (state == S_REQ);
        start     = (state == S_IDLE) && eoc_p && hit;
        capture   = (state == S_WAIT) && drp_drdy_p;
        expire    = (state == S_WAIT) && !drp_drdy_p && tc;
        upd       = (state == S_UPDATE);
    end

    always_ff @(posedge clk210_p) begin
        if (!reset_n_p) begin
            idx         <= '0;
            drp_daddr_p <= '0;
            tmr         <= '0;
            code_q      <= '0;
            data_p      <= '0;
            valid_p     <= '0;
            alarm_p     <= '0;
            timeout_p   <= 1'b0;
            overrun_p   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            valid_p <= '0;
            if (start) begin
                idx         <= hit_idx;
                drp_daddr_p <= hit_addr;
            end
            if (state == S_REQ)       tmr <= TW'(TIMEOUT);
            else if (state == S_WAIT) tmr <= tmr - TW'(1);
            if (capture) code_q <= drp_do_p[15:4];
            if (expire) timeout_p <= 1'b1;
            if (eoc_p && state != S_IDLE) overrun_p <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (upd && idx == IW'(i)) begin
                    if (wrap) begin
                        acc[i]            <= '0;
                        cnt[i]            <= '0;
                        data_p[16*i +: 16] <= {4'd0, result};
                        valid_p[i]        <= 1'b1;
                        if (result >= thr_sel)    alarm_p[i] <= 1'b1;
                        else if (result < thr_lo) alarm_p[i] <= 1'b0;
                    end else begin
                        acc[i] <= sum;
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xadc_multi_monitor.sv
// Bench for xadc_multi_monitor: a passthrough instance and a 4-sample averaging instance
// share one DRP stimulus stream and are checked against a sample-list reference model.
`timescale 1ns/1ps
module tb_xadc_multi_monitor;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        eoc = 1'b0;
    logic [4:0]  channel = 5'd0;
    logic [15:0] dout = 16'd0;
    logic        drdy = 1'b0;

    logic [6:0]  daddr0, daddr2;
    logic        den0, den2, dwe0, dwe2;
    logic [15:0] di0, di2;
    logic [63:0] data0, data2;
    logic [3:0]  valid0, valid2, alarm0, alarm2;
    logic        to0, to2, ov0, ov2;

    int n_checks = 0;
    int n_fail   = 0;
    int den_cnt0 = 0;
    int den_cnt2 = 0;

    always #2 clk = ~clk;

    xadc_multi_monitor #(.AVG_LOG2(0), .HI_THRESH({12'hFFF, 12'hFFF, 12'hFFF, 12'h800})) dut0 (
        .clk210_p(clk), .reset_n_p(reset_n), .eoc_p(eoc), .channel_p(channel),
        .drp_daddr_p(daddr0), .drp_den_p(den0), .drp_dwe_p(dwe0), .drp_di_p(di0),
        .drp_do_p(dout), .drp_drdy_p(drdy), .data_p(data0), .valid_p(valid0),
        .alarm_p(alarm0), .timeout_p(to0), .overrun_p(ov0));

    xadc_multi_monitor #(.AVG_LOG2(2)) dut2 (
        .clk210_p(clk), .reset_n_p(reset_n), .eoc_p(eoc), .channel_p(channel),
        .drp_daddr_p(daddr2), .drp_den_p(den2), .drp_dwe_p(dwe2), .drp_di_p(di2),
        .drp_do_p(dout), .drp_drdy_p(drdy), .data_p(data2), .valid_p(valid2),
        .alarm_p(alarm2), .timeout_p(to2), .overrun_p(ov2));

    always @(negedge clk) begin
        den_cnt0 <= den_cnt0 + int'(den0);
        den_cnt2 <= den_cnt2 + int'(den2);
    end

    // Reference model: index 0 = passthrough instance, index 1 = 4-sample average.
    logic [6:0]  addr_tab [4] = '{7'h00, 7'h01, 7'h02, 7'h06};
    int          navg [2]     = '{1, 4};
    int          thr  [2][4]  = '{'{12'h800, 12'hFFF, 12'hFFF, 12'hFFF},
                                   '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}};
    int          msum [2][4];
    int          mcnt [2][4];
    logic [63:0] e_data  [2];
    logic [3:0]  e_alarm [2];
    logic        e_to, e_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_data[d]  = '0;
            e_alarm[d] = '0;
            for (int c = 0; c < 4; c++) begin
                msum[d][c] = 0;
                mcnt[d][c] = 0;
            end
        end
        e_to = 1'b0;
        e_ov = 1'b0;
    endtask

    task automatic model_sample(input int ch, input int code, output logic [3:0] pv0, output logic [3:0] pv2);
        logic [3:0] pv [2];
        int res, lo;
        for (int d = 0; d < 2; d++) begin
            pv[d] = '0;
            msum[d][ch] += code;
            mcnt[d][ch] += 1;
            if (mcnt[d][ch] == navg[d]) begin
                res = msum[d][ch] / navg[d];
                lo  = (thr[d][ch] >= 16) ? thr[d][ch] - 16 : 0;
                e_data[d][16*ch +: 16] = 16'(res);
                if (res >= thr[d][ch])  e_alarm[d][ch] = 1'b1;
                else if (res < lo)      e_alarm[d][ch] = 1'b0;
                pv[d][ch]   = 1'b1;
                msum[d][ch] = 0;
                mcnt[d][ch] = 0;
            end
        end
        pv0 = pv[0];
        pv2 = pv[1];
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_data0"},  data0,  e_data[0]);
        chk({tag, "_data2"},  data2,  e_data[1]);
        chk({tag, "_alarm0"}, alarm0, e_alarm[0]);
        chk({tag, "_alarm2"}, alarm2, e_alarm[1]);
        chk({tag, "_timeout"}, {to2, to0}, {e_to, e_to});
        chk({tag, "_overrun"}, {ov2, ov0}, {e_ov, e_ov});
    endtask

    // One eoc-triggered read. idx<0: unmapped channel. dly<=0: drdy withheld (timeout).
    task automatic do_read(input logic [4:0] chv, input int idx, input logic [11:0] code,
                           input int dly, input bit mid_eoc);
        int d0, d2;
        logic [3:0] pv0, pv2;
        d0 = den_cnt0;
        d2 = den_cnt2;
        @(negedge clk); eoc = 1'b1; channel = chv;
        @(negedge clk); eoc = 1'b0; channel = 5'($urandom);
        if (idx < 0) begin
            repeat (3) @(negedge clk);
            chk("unmapped_no_den0", 64'(den_cnt0 - d0), 64'd0);
            chk("unmapped_no_den2", 64'(den_cnt2 - d2), 64'd0);
            check_state("unmapped");
            return;
        end
        chk("den_after_eoc", {den2, den0}, 2'b11);
        chk("daddr", {daddr2, daddr0}, {addr_tab[idx], addr_tab[idx]});
        if (dly <= 0) begin
            for (int k = 1; k <= TMO + 1; k++) begin
                @(negedge clk);
                if (k == TMO) chk("timeout_not_yet", {to2, to0}, {e_to, e_to});
            end
            e_to = 1'b1;
        end else begin
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                eoc = 1'b0;
                if (mid_eoc && k == 1) begin
                    eoc = 1'b1;
                    channel = chv;
                    e_ov = 1'b1;
                end
                if (k == dly) begin
                    drdy = 1'b1;
                    dout = {code, 4'($urandom)};
                end
            end
            @(negedge clk); drdy = 1'b0; eoc = 1'b0; dout = 16'($urandom);
            chk("valid_not_early", {valid2, valid0}, 8'h00);
            model_sample(idx, int'(code), pv0, pv2);
            @(negedge clk);
            chk("valid_pub", {valid2, valid0}, {pv2, pv0});
            check_state("pub");
            @(negedge clk);
            chk("valid_single", {valid2, valid0}, 8'h00);
        end
        chk("den_once0", 64'(den_cnt0 - d0), 64'd1);
        chk("den_once2", 64'(den_cnt2 - d2), 64'd1);
        check_state("read");
    endtask

    initial begin
        int ch, dly;
        logic [11:0] code;
        logic [4:0]  junk [5] = '{5'h03, 5'h05, 5'h07, 5'h10, 5'h1F};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_den_addr", {den2, den0, daddr2, daddr0}, 16'd0);
        chk("reset_valid", {valid2, valid0}, 8'h00);
        check_state("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("dwe_di_tied", {dwe2, dwe0, di2, di0}, 34'd0);

        // Single passthrough read of the die temperature.
        do_read(5'h00, 0, 12'hA6B, 3, 1'b0);
        chk("tp1_data_ch0", 64'(data0[15:0]), 64'h0A6B);

        // Four samples on ch1: only the averaging instance waits for the fourth.
        do_read(5'h01, 1, 12'd100, 2, 1'b0);
        do_read(5'h01, 1, 12'd101, 4, 1'b0);
        do_read(5'h01, 1, 12'd102, 1, 1'b0);
        do_read(5'h01, 1, 12'd104, 5, 1'b0);
        chk("tp2_avg_ch1", 64'(data2[31:16]), 64'd101);

        // Hysteresis on ch0 against 0x800 threshold.
        do_read(5'h00, 0, 12'h800, 2, 1'b0);
        chk("tp3_alarm_set", 64'(alarm0[0]), 64'd1);
        do_read(5'h00, 0, 12'h7F5, 2, 1'b0);
        chk("tp3_alarm_hold", 64'(alarm0[0]), 64'd1);
        do_read(5'h00, 0, 12'h7EF, 2, 1'b0);
        chk("tp3_alarm_clear", 64'(alarm0[0]), 64'd0);

        // Timeout, then a normal ch2 read; then the latest drdy still accepted.
        do_read(5'h02, 2, 12'h000, 0, 1'b0);
        do_read(5'h02, 2, 12'h5A5, 3, 1'b0);
        chk("tp4_ch2_after_timeout", 64'(data0[47:32]), 64'h05A5);
        do_read(5'h06, 3, 12'h321, TMO, 1'b0);

        // eoc during WAIT: overrun, no second den.
        do_read(5'h02, 2, 12'h111, 4, 1'b1);
        chk("tp5_overrun", {ov2, ov0}, 2'b11);

        do_read(5'h10, -1, 12'h000, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ch   = int'($urandom_range(0, 4));
            code = 12'($urandom);
            if ($urandom_range(0, 1) == 1) code = 12'($urandom_range(12'h7C0, 12'h840));
            dly  = int'($urandom_range(1, 12));
            if ($urandom_range(0, 15) == 0) dly = TMO;
            if ($urandom_range(0, 19) == 0) dly = 0;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); drdy = 1'b1; dout = 16'($urandom);
                @(negedge clk); drdy = 1'b0;
                @(negedge clk);
                chk("stray_drdy_valid", {valid2, valid0}, 8'h00);
            end
            if (ch == 4) do_read(junk[$urandom_range(0, 4)], -1, code, dly, 1'b0);
            else         do_read(5'(addr_tab[ch]), ch, code, dly, ($urandom_range(0, 4) == 0));
        end

        // Reset in WAIT, late drdy afterwards must be ignored.
        @(negedge clk); eoc = 1'b1; channel = 5'h01;
        @(negedge clk); eoc = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1; drdy = 1'b1; dout = 16'hFFF0;
        @(negedge clk); drdy = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rst_wait_no_valid", {valid2, valid0}, 8'h00);
            @(negedge clk);
        end
        chk("rst_wait_den_addr", {den2, den0, daddr2, daddr0}, 16'd0);
        check_state("rst_wait");

        do_read(5'h10, -1, 12'h000, 1, 1'b0);
        do_read(5'h06, 3, 12'h0C3, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
